tt_sweep_ctrl: RTL and testbench

Sequencer that drives every input combination into a combinational gate under test, waits a programmable settle time, captures the gate output and checks it against an expected truth-table vector. It replaces hand-written `for`-loop stimulus with a synthesizable controller that sits between a start/done host interface and one N-input, 1-output gate instance (e.g. the NAND-with-inverted-b gate). The captured truth table, mismatch count and a pass flag are held for the host after each sweep.

---
 rtl/tt_sweep_if.sv | 27 ++
 rtl/tt_sweep_ctrl.sv | 91 +++++++++
 tb/tb_tt_sweep_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_if.sv
// Host/gate bundle for tt_sweep_ctrl: sweep handshake, result registers and gate stimulus/response.
// slave = the sweep controller, master = host plus the gate under test.
interface tt_sweep_if #(
    parameter int N_IN = 2
) ();
    localparam int NV = 1 << N_IN;

    logic            start;
    logic [NV-1:0]   expected;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [NV-1:0]   table_out;
    logic [N_IN:0]   mismatch_count;
    logic            pass;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, table_out, mismatch_count, pass
    );

    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, table_out, mismatch_count, pass
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks all 2^N_IN input vectors, settles, captures and checks the gate output.
// Optional macro TT_SWEEP_ABORT_EN: stop the sweep at the first mismatching vector.
module tt_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    tt_sweep_if.slave bus
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MW = N_IN + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          miss;
    logic          last_vec;
    logic          end_sweep;
    logic [N_IN:0] mc_nxt;

    // dut_in doubles as the vector index; the two are always equal.
    always_comb begin
        miss      = (bus.dut_out != bus.expected[bus.dut_in]);
        last_vec  = (bus.dut_in == N_IN'(NV - 1));
        mc_nxt    = bus.mismatch_count + MW'(miss);
`ifdef TT_SWEEP_ABORT_EN
        end_sweep = last_vec | miss;
`else
        end_sweep = last_vec;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.dut_in         <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.table_out      <= '0;
            bus.mismatch_count <= '0;
            bus.pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state              <= WAIT;
                        cnt                <= '0;
                        bus.dut_in         <= '0;
                        bus.busy           <= 1'b1;
                        bus.table_out      <= '0;
                        bus.mismatch_count <= '0;
                        bus.pass           <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    bus.table_out[bus.dut_in] <= bus.dut_out;
                    bus.mismatch_count        <= mc_nxt;
                    // Terminal check comes first so the index never wraps.
                    if (end_sweep) begin
                        state    <= FINISH;
                        bus.done <= 1'b1;
                        bus.pass <= (mc_nxt == '0);
                    end else begin
                        state      <= WAIT;
                        cnt        <= '0;
                        bus.dut_in <= bus.dut_in + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: 2-input/SETTLE=2 and 3-input/SETTLE=1 instances against a truth-table sweep model.
module tb_tt_sweep_ctrl;
`ifdef TT_SWEEP_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    bit   sel;
    int   gsel;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tt_sweep_if #(.N_IN(2)) if2 ();
    tt_sweep_if #(.N_IN(3)) if3 ();

    tt_sweep_ctrl #(.N_IN(2), .SETTLE(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
    tt_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    // Gate models: g=0 is NAND(a,~b) for 2 inputs and AND3 for 3 inputs.
    function automatic logic gfun2(input int g, input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        case (g)
            0:       return ~(a & ~b);
            1:       return a ^ b;
            2:       return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic gfun3(input int g, input logic [2:0] v);
        return (g == 0) ? (&v) : (^v);
    endfunction

    function automatic logic [7:0] truth(input bit s, input int g);
        logic [7:0] t = '0;
        for (int v = 0; v < (s ? 8 : 4); v++) begin
            logic [2:0] vv = v[2:0];
            t[v] = s ? gfun3(g, vv) : gfun2(g, vv[1:0]);
        end
        return t;
    endfunction

    assign if2.dut_out = gfun2(gsel, if2.dut_in);
    assign if3.dut_out = gfun3(gsel, if3.dut_in);

    logic       done_s, busy_s, pass_s;
    logic [7:0] table_s;
    logic [3:0] mc_s;
    logic [2:0] dut_in_s;
    assign done_s   = sel ? if3.done : if2.done;
    assign busy_s   = sel ? if3.busy : if2.busy;
    assign pass_s   = sel ? if3.pass : if2.pass;
    assign table_s  = sel ? if3.table_out : {4'b0, if2.table_out};
    assign mc_s     = sel ? if3.mismatch_count : {1'b0, if2.mismatch_count};
    assign dut_in_s = sel ? if3.dut_in : {1'b0, if2.dut_in};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep with the expected sweep outcome derived from the gate truth table.
    task automatic run_sweep(input bit s, input logic [7:0] exp, input int g, input string tag);
        int nv, st, last, mc, done_k, k, di;
        logic [7:0] tbl, tt;
        sel  = s;
        gsel = g;
        nv   = s ? 8 : 4;
        st   = s ? 1 : 2;
        tt   = truth(s, g);
        last = nv - 1;
        mc   = 0;
        tbl  = '0;
        for (int v = 0; v < nv; v++) begin
            tbl[v] = tt[v];
            if (tt[v] != exp[v]) begin
                mc++;
                if (ABORT) begin
                    last = v;
                    break;
                end
            end
        end
        done_k = (last + 1) * (st + 1);

        @(negedge clk);
        if (s) begin if3.expected = exp;      if3.start = 1'b1; end
        else   begin if2.expected = exp[3:0]; if2.start = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        if3.start = 1'b0;
        for (k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            di = k / (st + 1);
            if (di > last) di = last;
            chk({tag, " dut_in"}, 32'(dut_in_s), 32'(di));
            chk({tag, " busy"}, 32'(busy_s), 32'd1);
            if (done_s) break;
        end
        chk({tag, " done_cycle"}, 32'(k), 32'(done_k));
        chk({tag, " table"}, 32'(table_s), 32'(tbl));
        chk({tag, " mismatch"}, 32'(mc_s), 32'(mc));
        chk({tag, " pass"}, 32'(pass_s), 32'(mc == 0));
        @(posedge clk);
        #1;
        chk({tag, " done_drop"}, 32'(done_s), 32'd0);
        chk({tag, " busy_drop"}, 32'(busy_s), 32'd0);
        chk({tag, " dut_in_hold"}, 32'(dut_in_s), 32'(last));
    endtask

    initial begin
        int ndone, d1, d2, b13, b14;
        reset        = 1'b1;
        sel          = 1'b0;
        gsel         = 0;
        if2.start    = 1'b0;
        if3.start    = 1'b0;
        if2.expected = '0;
        if3.expected = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(if2.busy), 32'd0);
        chk("rst done", 32'(if2.done), 32'd0);
        chk("rst dut_in", 32'(if2.dut_in), 32'd0);
        chk("rst table", 32'(if3.table_out), 32'd0);
        chk("rst mc", 32'(if3.mismatch_count), 32'd0);
        chk("rst pass", 32'(if2.pass), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_sweep(1'b0, 8'h0b, 0, "nand_nb");
        run_sweep(1'b0, 8'h0f, 0, "nand_nb_bad");
        run_sweep(1'b1, 8'h80, 0, "and3");

        // Asynchronous reset in the middle of a sweep, mid-cycle.
        sel  = 1'b0;
        gsel = 0;
        @(negedge clk);
        if2.expected = 4'b1011;
        if2.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst busy", 32'(if2.busy), 32'd0);
        chk("arst dut_in", 32'(if2.dut_in), 32'd0);
        chk("arst table", 32'(if2.table_out), 32'd0);
        chk("arst mc", 32'(if2.mismatch_count), 32'd0);
        chk("arst done", 32'(if2.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (if2.done) ndone++;
        end
        chk("arst no_done", 32'(ndone), 32'd0);
        run_sweep(1'b0, 8'h0b, 0, "after_rst");

        // start held high: one IDLE cycle between back-to-back sweeps.
        @(negedge clk);
        if2.expected = 4'b1011;
        if2.start    = 1'b1;
        @(posedge clk);
        ndone = 0; d1 = 0; d2 = 0; b13 = -1; b14 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (if2.done) begin
                ndone++;
                if (ndone == 1) d1 = k;
                if (ndone == 2) d2 = k;
            end
            if (k == 13) b13 = int'(if2.busy);
            if (k == 14) b14 = int'(if2.busy);
        end
        chk("hold ndone", 32'(ndone), 32'd2);
        chk("hold first", 32'(d1), 32'd12);
        chk("hold second", 32'(d2), 32'd26);
        chk("hold idle_gap", 32'(b13), 32'd0);
        chk("hold restart", 32'(b14), 32'd1);
        @(negedge clk);
        if2.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            bit         s;
            int         g;
            logic [7:0] e;
            s = 1'($urandom_range(0, 1));
            g = int'($urandom_range(0, 3));
            e = truth(s, g) ^ ((r % 2 == 1) ? 8'($urandom) : 8'h00);
            run_sweep(s, e, g, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
